pll_lock_supervisor: RTL and testbench

PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

---
 rtl/pll_sup_pkg.sv | 24 ++
 rtl/sync_2ff.sv | 25 ++
 rtl/pll_lock_supervisor.sv | 129 ++++++++++++
 tb/tb_pll_lock_supervisor.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_sup_pkg.sv
// Shared state encoding and parameter defaults for the PLL lock supervisor.
// Compile first; imported by pll_lock_supervisor.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_e;

    localparam int DEF_RST_CYCLES   = 10;
    localparam int DEF_LOCK_TIMEOUT = 50000;
    localparam int DEF_LOCK_STABLE  = 1000;
    localparam int DEF_MAX_RETRIES  = 3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; 2 clk latency, resets to 0.
// No flow control: the level is sampled every clock.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL bring-up supervisor: pulses pll_rst, waits for a stable lock, retries, faults.
// All outputs are registered from the next state so they move on the same edge as state.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_CYCLES   = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
    parameter int LOCK_STABLE  = DEF_LOCK_STABLE,
    parameter int MAX_RETRIES  = DEF_MAX_RETRIES
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       fault,
    output logic [2:0] state,
    output logic [3:0] retry_cnt,
    output logic [7:0] lock_loss_cnt
);

    localparam int CNT_MAX = max3(RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE);
    localparam int CW      = $clog2(CNT_MAX + 1);

    logic          locked_s;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    retry_q, retry_d;
    logic [7:0]    loss_q, loss_d;
    logic          pll_rst_q, pll_rst_d;
    logic          sys_rst_n_q, sys_rst_n_d;
    logic          ready_q, ready_d;
    logic          fault_q, fault_d;

    sync_2ff u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (locked_s)
    );

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        loss_d  = loss_q;
        case (state_q)
            RESET_PLL: begin
                if (cnt_q == CW'(RST_CYCLES - 1)) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = STABLE;
                end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
                    retry_d = retry_q + 4'd1;
                    state_d = (retry_q + 4'd1 == 4'(MAX_RETRIES)) ? FAULT : RESET_PLL;
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == CW'(LOCK_STABLE - 1)) begin
                    state_d = RUN;
                    retry_d = '0;
                end
            end
            RUN: begin
                // Loss is counted even when a relock request overrides the transition.
                if (!locked_s) begin
                    state_d = RESET_PLL;
                    if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
                end
            end
            FAULT:   state_d = FAULT;
            default: state_d = RESET_PLL;
        endcase

        if (relock_req) begin
            state_d = RESET_PLL;
            retry_d = '0;
        end

        // Clear on any state change (relock restarts RESET_PLL too); saturate while idling in RUN/FAULT.
        if (state_d != state_q || relock_req) begin
            cnt_d = '0;
        end else if (cnt_q != CW'(CNT_MAX)) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end

        pll_rst_d   = (state_d == RESET_PLL) || (state_d == FAULT);
        sys_rst_n_d = (state_d == RUN);
        ready_d     = (state_d == RUN);
        fault_d     = (state_d == FAULT);
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RESET_PLL;
            cnt_q       <= '0;
            retry_q     <= '0;
            loss_q      <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
            pll_rst_q   <= pll_rst_d;
            sys_rst_n_q <= sys_rst_n_d;
            ready_q     <= ready_d;
            fault_q     <= fault_d;
        end
    end

    assign pll_rst       = pll_rst_q;
    assign sys_rst_n     = sys_rst_n_q;
    assign ready         = ready_q;
    assign fault         = fault_q;
    assign state         = state_q;
    assign retry_cnt     = retry_q;
    assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor with RST_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE=8, MAX_RETRIES=2.
module tb_pll_lock_supervisor;

    localparam int RC = 4;
    localparam int LT = 20;
    localparam int LS = 8;
    localparam int MR = 2;

    logic       refclk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       relock_req = 1'b0;
    logic       pll_rst, sys_rst_n, ready, fault;
    logic [2:0] state;
    logic [3:0] retry_cnt;
    logic [7:0] lock_loss_cnt;

    pll_lock_supervisor #(
        .RST_CYCLES   (RC),
        .LOCK_TIMEOUT (LT),
        .LOCK_STABLE  (LS),
        .MAX_RETRIES  (MR)
    ) dut (
        .refclk        (refclk),
        .rst_n         (rst_n),
        .pll_locked    (pll_locked),
        .relock_req    (relock_req),
        .pll_rst       (pll_rst),
        .sys_rst_n     (sys_rst_n),
        .ready         (ready),
        .fault         (fault),
        .state         (state),
        .retry_cnt     (retry_cnt),
        .lock_loss_cnt (lock_loss_cnt)
    );

    always #5 refclk = ~refclk;

    typedef struct {
        logic [2:0] st;
        logic       prst;
        logic       srn;
        logic       rdy;
        logic       flt;
        logic [3:0] rty;
        logic [7:0] loss;
    } exp_t;

    typedef struct {
        logic lk;
        logic rq;
        exp_t e;
    } vec_t;

    vec_t vecs_boot[$];
    vec_t vecs_glitch[$];
    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   exp_loss = 0;

    function automatic exp_t mk(input logic [2:0] st, input logic [3:0] rty, input logic [7:0] loss);
        exp_t e;
        e.st   = st;
        e.prst = (st == 3'd0) || (st == 3'd4);
        e.srn  = (st == 3'd3);
        e.rdy  = (st == 3'd3);
        e.flt  = (st == 3'd4);
        e.rty  = rty;
        e.loss = loss;
        return e;
    endfunction

    function automatic vec_t mv(input logic lk, input logic rq, input exp_t e);
        vec_t v;
        v.lk = lk;
        v.rq = rq;
        v.e  = e;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock: inputs change on the falling edge, outputs are sampled 1 ns after the rising edge.
    task automatic drive(input logic lk, input logic rq);
        @(negedge refclk);
        pll_locked = lk;
        relock_req = rq;
        @(posedge refclk);
        #1;
        relock_req = 1'b0;
    endtask

    task automatic cmp_exp(input string nm);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, got state %0d, expected an entry", nm, state);
        end else begin
            e = exp_q.pop_front();
            chk({nm, " state"}, state, e.st);
            chk({nm, " pll_rst"}, pll_rst, e.prst);
            chk({nm, " sys_rst_n"}, sys_rst_n, e.srn);
            chk({nm, " ready"}, ready, e.rdy);
            chk({nm, " fault"}, fault, e.flt);
            chk({nm, " retry_cnt"}, retry_cnt, e.rty);
            chk({nm, " lock_loss_cnt"}, lock_loss_cnt, e.loss);
        end
    endtask

    task automatic apply(input string nm, input vec_t v);
        exp_q.push_back(v.e);
        drive(v.lk, v.rq);
        cmp_exp(nm);
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string nm);
        int n = 0;
        while (state !== s && n < budget) begin
            drive(pll_locked, 1'b0);
            n++;
        end
        chk(nm, state, s);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, state %0d", state);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int hi;
        int w;

        // Bring-up after reset release: lock appears 3 cycles after pll_rst falls.
        for (int i = 0; i < 3; i++) vecs_boot.push_back(mv(1'b0, 1'b0, mk(3'd0, 4'd0, 8'd0)));
        for (int i = 0; i < 3; i++) vecs_boot.push_back(mv(1'b0, 1'b0, mk(3'd1, 4'd0, 8'd0)));
        for (int i = 0; i < 2; i++) vecs_boot.push_back(mv(1'b1, 1'b0, mk(3'd1, 4'd0, 8'd0)));
        for (int i = 0; i < 8; i++) vecs_boot.push_back(mv(1'b1, 1'b0, mk(3'd2, 4'd0, 8'd0)));
        for (int i = 0; i < 2; i++) vecs_boot.push_back(mv(1'b1, 1'b0, mk(3'd3, 4'd0, 8'd0)));

        // One-cycle lock glitch at STABLE count 5, then 8 clean STABLE cycles before RUN.
        for (int i = 0; i < 4; i++) vecs_glitch.push_back(mv(1'b1, 1'b0, mk(3'd2, 4'd0, 8'd1)));
        vecs_glitch.push_back(mv(1'b0, 1'b0, mk(3'd2, 4'd0, 8'd1)));
        vecs_glitch.push_back(mv(1'b1, 1'b0, mk(3'd2, 4'd0, 8'd1)));
        vecs_glitch.push_back(mv(1'b1, 1'b0, mk(3'd1, 4'd0, 8'd1)));
        for (int i = 0; i < 8; i++) vecs_glitch.push_back(mv(1'b1, 1'b0, mk(3'd2, 4'd0, 8'd1)));
        vecs_glitch.push_back(mv(1'b1, 1'b0, mk(3'd3, 4'd0, 8'd1)));

        repeat (3) @(posedge refclk);
        #1;
        exp_q.push_back(mk(3'd0, 4'd0, 8'd0));
        cmp_exp("in_reset");
        rst_n = 1'b1;

        foreach (vecs_boot[i]) apply($sformatf("boot[%0d]", i), vecs_boot[i]);

        // Relock request alone in RUN: back to RESET_PLL, loss count untouched.
        exp_q.push_back(mk(3'd0, 4'd0, 8'd0));
        drive(1'b1, 1'b1);
        cmp_exp("relock_in_run");
        wait_state(3'd3, 40, "rerun_after_relock");

        // Lock loss and relock in the same RUN cycle: relock wins, loss still counted.
        drive(1'b0, 1'b0);
        drive(1'b1, 1'b0);
        chk("run_before_combined", state, 3'd3);
        exp_loss = 1;
        exp_q.push_back(mk(3'd0, 4'd0, 8'(exp_loss)));
        drive(1'b1, 1'b1);
        cmp_exp("loss_plus_relock");

        wait_state(3'd2, 40, "enter_stable");
        foreach (vecs_glitch[i]) apply($sformatf("glitch[%0d]", i), vecs_glitch[i]);

        // Repeated lock drops in RUN; loss counter must saturate at 255.
        for (int i = 0; i < 300; i++) begin
            drive(1'b0, 1'b0);
            n = 1;
            while (sys_rst_n !== 1'b0 && n < 3) begin
                drive(1'b1, 1'b0);
                n++;
            end
            chk($sformatf("drop%0d sys_rst_n", i), sys_rst_n, 1'b0);
            hi = 0;
            while (pll_rst === 1'b1 && hi < 10) begin
                hi++;
                drive(1'b1, 1'b0);
            end
            chk($sformatf("drop%0d pll_rst_len", i), hi, RC);
            if (exp_loss < 255) exp_loss++;
            chk($sformatf("drop%0d lock_loss_cnt", i), lock_loss_cnt, exp_loss);
            wait_state(3'd3, 30, $sformatf("drop%0d rerun", i));
        end
        chk("loss_saturated", lock_loss_cnt, 8'd255);

        // Lock never comes back: two timeout windows, then FAULT.
        drive(1'b0, 1'b0);
        wait_state(3'd0, 5, "lost_to_reset");
        for (int k = 1; k <= MR; k++) begin
            wait_state(3'd1, 10, $sformatf("wait_lock%0d", k));
            w = 0;
            while (state === 3'd1 && w < 40) begin
                w++;
                drive(1'b0, 1'b0);
            end
            chk($sformatf("window%0d_len", k), w, LT);
            chk($sformatf("retry_after%0d", k), retry_cnt, k);
        end
        exp_q.push_back(mk(3'd4, 4'd2, 8'd255));
        cmp_exp("fault_entry");
        repeat (30) drive(1'b0, 1'b0);
        exp_q.push_back(mk(3'd4, 4'd2, 8'd255));
        cmp_exp("fault_held");
        exp_q.push_back(mk(3'd0, 4'd0, 8'd255));
        drive(1'b0, 1'b1);
        cmp_exp("fault_relock");

        // Asynchronous reset in STABLE, then a full pll_rst pulse, then reset again in RUN.
        pll_locked = 1'b1;
        wait_state(3'd2, 40, "stable_before_rst");
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(mk(3'd0, 4'd0, 8'd0));
        cmp_exp("async_rst_stable");
        rst_n = 1'b1;
        n = 0;
        do begin
            drive(1'b1, 1'b0);
            n++;
        end while (pll_rst === 1'b1 && n < 10);
        chk("post_rst_pll_rst_len", n, RC);
        wait_state(3'd3, 40, "run_before_rst");
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.push_back(mk(3'd0, 4'd0, 8'd0));
        cmp_exp("async_rst_run");
        rst_n = 1'b1;
        drive(1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
